clk_div_en: RTL and testbench

CLK_DIV_EN -- requirements
Module: clk_div_en

---
 rtl/clk_pkg.sv | 16 +
 rtl/sync2.sv | 22 ++
 rtl/clk_div_en.sv | 98 +++++++++
 tb/tb_clk_div_en.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared constants and state encoding for
// phase-accumulator divided clock-enable generators.
package clk_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN
  } state_t;

  // 4.194304 MHz from 33 MHz, scaled by 2^32
  localparam logic [31:0] DEF_INC = 32'd545890864;
  localparam int DEF_LOCK_CYCLES = 1024;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous
// level, cleared by an asynchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/clk_div_en.sv
// Lock-qualified fractional clock-enable generator:
// waits for a stable DCM lock, then emits cpu/mcyc pulses.
module clk_div_en
  import clk_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter logic [ACC_W-1:0] INC = ACC_W'(DEF_INC),
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk33,
  input  logic rst_n,
  input  logic dcm_ready,
  input  logic pause,
  output logic sys_rst_n,
  output logic cpu_en,
  output logic mcyc_en,
  output logic running
);

  localparam int CNT_W =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LOCK_CYCLES - 1);

  state_t           state;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [1:0]       qtr;
  logic [ACC_W:0]   sum;
  logic             carry;

  sync2 u_sync (
    .clk   (clk33),
    .rst_n (rst_n),
    .d     (dcm_ready),
    .q     (lock_s)
  );

  // bit ACC_W is the wrap-around that marks an enable
  assign sum   = {1'b0, acc} + {1'b0, INC};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk33 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      cnt       <= '0;
      acc       <= '0;
      qtr       <= '0;
      sys_rst_n <= 1'b0;
      cpu_en    <= 1'b0;
      mcyc_en   <= 1'b0;
      running   <= 1'b0;
    end else begin
      sys_rst_n <= (state == ST_RUN);
      cpu_en    <= 1'b0;
      mcyc_en   <= 1'b0;
      unique case (state)
        ST_RESET: begin
          state <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
          end else if (cnt == LAST) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state   <= ST_WAIT_LOCK;
            running <= 1'b0;
            acc     <= '0;
            qtr     <= '0;
          end else if (!pause) begin
            acc     <= sum[ACC_W-1:0];
            cpu_en  <= carry;
            mcyc_en <= carry && (qtr == 2'd3);
            qtr     <= qtr + {1'b0, carry};
          end
        end
        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_en.sv
// Directed bench for clk_div_en: lock sequencing,
// INC=4/3/0 pulse patterns, pause, lock loss, reset.
module tb_clk_div_en;

  logic clk33 = 1'b0;
  logic rst_n = 1'b0;
  logic dcm_ready = 1'b0;
  logic pause = 1'b0;

  logic s4, c4, m4, r4;
  logic s3, c3, m3, r3;
  logic s0, c0, m0, r0;

  int n_chk = 0;
  int n_pass = 0;
  int n3 = 0;

  always #5 clk33 = ~clk33;

  clk_div_en #(
    .ACC_W(4), .INC(4'd4), .LOCK_CYCLES(4)
  ) d4 (
    .clk33(clk33), .rst_n(rst_n),
    .dcm_ready(dcm_ready), .pause(pause),
    .sys_rst_n(s4), .cpu_en(c4),
    .mcyc_en(m4), .running(r4)
  );

  clk_div_en #(
    .ACC_W(4), .INC(4'd3), .LOCK_CYCLES(4)
  ) d3 (
    .clk33(clk33), .rst_n(rst_n),
    .dcm_ready(dcm_ready), .pause(pause),
    .sys_rst_n(s3), .cpu_en(c3),
    .mcyc_en(m3), .running(r3)
  );

  clk_div_en #(
    .ACC_W(4), .INC(4'd0), .LOCK_CYCLES(4)
  ) d0 (
    .clk33(clk33), .rst_n(rst_n),
    .dcm_ready(dcm_ready), .pause(pause),
    .sys_rst_n(s0), .cpu_en(c0),
    .mcyc_en(m0), .running(r0)
  );

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk33);
    #1;
  endtask

  // INC=3 carry points counted from RUN entry
  function automatic int p3(input int r);
    return (r inside {6, 11, 16, 22, 27,
                      32, 38, 43, 48}) ? 1 : 0;
  endfunction

  initial begin
    repeat (3) tick();
    chk("rst_sys", s4, 0);
    chk("rst_run", r4, 0);
    chk("rst_cpu", c4, 0);
    chk("rst_mcyc", m4, 0);

    @(negedge clk33);
    dcm_ready = 1'b1;
    rst_n = 1'b1;
    repeat (6) tick();
    chk("lock_pre_run", r4, 0);
    tick();
    chk("lock_run4", r4, 1);
    chk("lock_run3", r3, 1);
    chk("lock_sys_lag", s4, 0);

    for (int r = 1; r <= 48; r++) begin
      tick();
      if (r == 1) chk("sys_rise", s4, 1);
      chk("inc4_cpu", c4, (r % 4 == 0) ? 1 : 0);
      chk("inc4_mcyc", m4, (r % 16 == 0) ? 1 : 0);
      chk("inc3_cpu", c3, p3(r));
      chk("inc0_cpu", c0, 0);
      chk("inc0_mcyc", m0, 0);
      n3 += int'(c3);
    end
    chk("inc3_count48", n3, 9);

    repeat (2) tick();
    chk("pre_pause4", c4, 0);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_cpu4", c4, 0);
      chk("pause_mcyc4", m4, 0);
      chk("pause_cpu3", c3, 0);
      chk("pause_run", r4, 1);
    end
    pause = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("resume_cpu4", c4, (i == 2) ? 1 : 0);
      chk("resume_cpu3", c3, (i == 4) ? 1 : 0);
    end

    dcm_ready = 1'b0;
    repeat (2) tick();
    chk("loss_sync_lat", r4, 1);
    tick();
    chk("loss_run", r4, 0);
    chk("loss_sys_lag", s4, 1);
    chk("loss_cpu", c4, 0);
    chk("loss_mcyc", m4, 0);
    tick();
    chk("loss_sys", s4, 0);

    dcm_ready = 1'b1;
    repeat (3) tick();
    dcm_ready = 1'b0;
    tick();
    dcm_ready = 1'b1;
    repeat (6) tick();
    chk("glitch_delay", r4, 0);
    tick();
    chk("glitch_run", r4, 1);

    for (int r = 1; r <= 16; r++) begin
      tick();
      chk("relock_cpu4", c4, (r % 4 == 0) ? 1 : 0);
      chk("relock_mcyc4", m4, (r == 16) ? 1 : 0);
      chk("relock_cpu3", c3, p3(r));
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cpu4", c4, 0);
    chk("arst_mcyc4", m4, 0);
    chk("arst_cpu3", c3, 0);
    chk("arst_run", r4, 0);
    chk("arst_sys", s4, 0);

    repeat (2) tick();
    @(negedge clk33);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rerst_pre_run", r4, 0);
    tick();
    chk("rerst_run", r4, 1);
    chk("rerst_sys_lag", s4, 0);
    for (int r = 1; r <= 4; r++) begin
      tick();
      chk("rerst_cpu4", c4, (r == 4) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
